// File: rtl/cpu7_icu_req_arb_if.sv
// ICU fetch-port sharing bus: two requesters, one ICU port.
// slave = arbiter view, master = requesters + ICU view.
interface cpu7_icu_req_arb_if;
    logic        r0_req_ic1;
    logic [31:0] r0_addr_ic1;
    logic        r0_cancel;
    logic        r0_ack_ic1;
    logic [63:0] r0_data_ic2;
    logic        r0_data_valid_ic2;
    logic        r1_req_ic1;
    logic [31:0] r1_addr_ic1;
    logic        r1_ack_ic1;
    logic [63:0] r1_data_ic2;
    logic        r1_data_valid_ic2;
    logic        arb_icu_req_ic1;
    logic [31:0] arb_icu_addr_ic1;
    logic        icu_arb_ack_ic1;
    logic        arb_icu_cancel;
    logic [63:0] icu_arb_data_ic2;
    logic        icu_arb_data_valid_ic2;
    logic        arb_busy;

    modport slave (
        input  r0_req_ic1, r0_addr_ic1, r0_cancel,
        output r0_ack_ic1, r0_data_ic2, r0_data_valid_ic2,
        input  r1_req_ic1, r1_addr_ic1,
        output r1_ack_ic1, r1_data_ic2, r1_data_valid_ic2,
        output arb_icu_req_ic1, arb_icu_addr_ic1, arb_icu_cancel,
        input  icu_arb_ack_ic1, icu_arb_data_ic2, icu_arb_data_valid_ic2,
        output arb_busy
    );

    modport master (
        output r0_req_ic1, r0_addr_ic1, r0_cancel,
        input  r0_ack_ic1, r0_data_ic2, r0_data_valid_ic2,
        output r1_req_ic1, r1_addr_ic1,
        input  r1_ack_ic1, r1_data_ic2, r1_data_valid_ic2,
        input  arb_icu_req_ic1, arb_icu_addr_ic1, arb_icu_cancel,
        output icu_arb_ack_ic1, icu_arb_data_ic2, icu_arb_data_valid_ic2,
        input  arb_busy
    );
endinterface

// File: rtl/cpu7_icu_req_arb.sv
// ICU fetch-port arbiter: IFU (req 0) vs aux reader (req 1).
// One outstanding transaction, starvation-bounded for req 1.
module cpu7_icu_req_arb #(
    parameter int STARVE_LIM = 8,
    parameter int CW         = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    cpu7_icu_req_arb_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN0 = 2'd1,
        S_OWN1 = 2'd2
    } state_t;

    localparam logic [CW-1:0] LP_LIM = CW'(STARVE_LIM);
    localparam logic [CW-1:0] LP_ONE = CW'(1);
    localparam logic [CW-1:0] LP_MAX = '1;

    state_t        r_state;
    logic [CW-1:0] r_starve_cnt;

    logic w_idle;
    logic w_own0;
    logic w_own1;
    logic w_starved;
    logic w_gnt0;
    logic w_gnt1;
    logic w_ack0;
    logic w_ack1;
    logic w_cancel;

    // Grant decision is combinational in IDLE so requests see no added latency.
    always_comb begin
        w_idle    = (r_state == S_IDLE);
        w_own0    = (r_state == S_OWN0);
        w_own1    = (r_state == S_OWN1);
        w_starved = (r_starve_cnt >= LP_LIM);
        w_gnt1    = w_idle & bus.r1_req_ic1
                  & (~bus.r0_req_ic1 | w_starved);
        w_gnt0    = w_idle & bus.r0_req_ic1 & ~w_gnt1;
        w_ack0    = w_gnt0 & bus.icu_arb_ack_ic1;
        w_ack1    = w_gnt1 & bus.icu_arb_ack_ic1;
        w_cancel  = w_own0 & bus.r0_cancel;
    end

    // Route request/address to the ICU and ack/data back to the owner.
    always_comb begin
        bus.arb_icu_req_ic1  = w_gnt0 | w_gnt1;
        bus.arb_icu_addr_ic1 = '0;
        unique case (1'b1)
            w_gnt1:  bus.arb_icu_addr_ic1 = bus.r1_addr_ic1;
            w_gnt0:  bus.arb_icu_addr_ic1 = bus.r0_addr_ic1;
            default: bus.arb_icu_addr_ic1 = '0;
        endcase
        bus.r0_ack_ic1        = w_ack0;
        bus.r1_ack_ic1        = w_ack1;
        bus.arb_icu_cancel    = w_cancel;
        bus.r0_data_ic2       = bus.icu_arb_data_ic2;
        bus.r1_data_ic2       = bus.icu_arb_data_ic2;
        bus.r0_data_valid_ic2 = w_own0 & bus.icu_arb_data_valid_ic2
                              & ~bus.r0_cancel;
        bus.r1_data_valid_ic2 = w_own1 & bus.icu_arb_data_valid_ic2;
        bus.arb_busy          = ~w_idle;
    end

    // Ownership FSM; stray ICU ack/valid in the wrong state is ignored.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_ack0)
                        r_state <= S_OWN0;
                    else if (w_ack1)
                        r_state <= S_OWN1;
                end
                S_OWN0: begin
                    if (bus.r0_cancel | bus.icu_arb_data_valid_ic2)
                        r_state <= S_IDLE;
                end
                S_OWN1: begin
                    if (bus.icu_arb_data_valid_ic2)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Count IFU wins while req 1 waits; clear once req 1 is served or idle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_starve_cnt <= '0;
        end else if (w_ack1 | ~bus.r1_req_ic1) begin
            r_starve_cnt <= '0;
        end else if (w_ack0 && (r_starve_cnt != LP_MAX)) begin
            r_starve_cnt <= r_starve_cnt + LP_ONE;
        end
    end

endmodule
